pe_border_et: RTL and testbench

- Next-generation unary-rate border processing element for the systolic array, parametrised in data and accumulator width.
- Latches a signed input and sign/magnitude weight on `start`, then generates rate-coded bitstreams internally from a counter-based source.
- The bitstream length is runtime-selectable (2^len_log2 cycles), which allows early termination; the partial count is rescaled to full precision before being added to `ofm`.
- It streams the input bit and weight-side random number east, and drives the saturated partial sum south with a done pulse.

---
 rtl/pe_border_et.sv | 212 +++++++++++++++++++++
 tb/tb_pe_border_et.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_border_et.sv
// pe_border_et - unary-rate border processing element for the systolic array.
//
// The block latches a signed activation and a sign/magnitude weight on start.
// It then streams 2^L rate-coded bits and counts the cycles where both the
// activation stream and the weight stream are high. The count is rescaled back
// to full precision and added to the incoming partial sum, with saturation.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, clr       begin a MAC (sampled in IDLE only), synchronous abort
//   len_log2         stream length exponent L (clamped to IWIDTH-1)
//   ifm              signed activation
//   wght_sign/abs    weight in sign/magnitude form
//   ofm              incoming partial sum from the north
//   busy             high while a MAC is in RUN or DONE
//   start_d, len_d   accepted-start pulse and latched L, for the east neighbour
//   stream_vld_d     qualifies ifm_bit_d / randW_d
//   ifm_sign_d, ifm_bit_d, randW_d, wght_sign_d, wght_abs_d   east streams
//   ofm_d, mac_done_d  saturated result towards the south, one-cycle valid pulse
module pe_border_et #(
    parameter int IWIDTH = 8,
    parameter int OWIDTH = 16,
    parameter int LWIDTH = $clog2(IWIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                clr,
    input  logic [LWIDTH-1:0]   len_log2,
    input  logic [IWIDTH-1:0]   ifm,
    input  logic                wght_sign,
    input  logic [IWIDTH-2:0]   wght_abs,
    input  logic [OWIDTH-1:0]   ofm,
    output logic                busy,
    output logic                start_d,
    output logic [LWIDTH-1:0]   len_d,
    output logic                stream_vld_d,
    output logic                ifm_sign_d,
    output logic                ifm_bit_d,
    output logic [IWIDTH-2:0]   randW_d,
    output logic                wght_sign_d,
    output logic [IWIDTH-2:0]   wght_abs_d,
    output logic [OWIDTH-1:0]   ofm_d,
    output logic                mac_done_d
);

    localparam int MW = IWIDTH - 1;
    // Sum width large enough for ofm plus the rescaled count without wrap.
    localparam int SW = ((OWIDTH > 2 * IWIDTH) ? OWIDTH : 2 * IWIDTH) + 2;
    localparam logic [LWIDTH-1:0]   LMAX = LWIDTH'(MW);
    localparam logic signed [SW-1:0] OMAX = {{(SW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] OMIN = {{(SW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};
    localparam logic signed [IWIDTH:0] ACC_ONE = (IWIDTH+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Magnitude of a two's complement value; the most negative code saturates.
    function automatic logic [MW-1:0] sat_abs(input logic [IWIDTH-1:0] v);
        logic [IWIDTH-1:0] neg;
        neg = ~v + IWIDTH'(1);
        if (!v[IWIDTH-1]) begin
            sat_abs = v[MW-1:0];
        end else if (v[MW-1:0] == {MW{1'b0}}) begin
            sat_abs = {MW{1'b1}};
        end else begin
            sat_abs = neg[MW-1:0];
        end
    endfunction

    // Full-width bit reversal. Because the count never exceeds 2^L-1, the
    // reversed value already equals bitrev_L(c) << (MW-L).
    function automatic logic [MW-1:0] bitrev(input logic [MW-1:0] v);
        for (int i = 0; i < MW; i++) begin
            bitrev[MW-1-i] = v[i];
        end
    endfunction

    // Clamp a wide signed sum into the OWIDTH range.
    function automatic logic [OWIDTH-1:0] sat_o(input logic signed [SW-1:0] v);
        if (v > OMAX) begin
            sat_o = OMAX[OWIDTH-1:0];
        end else if (v < OMIN) begin
            sat_o = OMIN[OWIDTH-1:0];
        end else begin
            sat_o = v[OWIDTH-1:0];
        end
    endfunction

    state_t                  state_r;
    logic [MW-1:0]           cnt_r;
    logic signed [IWIDTH:0]  acc_r;
    logic [MW-1:0]           ifm_abs_r;
    logic                    busy_r, start_d_r, stream_vld_r, ifm_sign_r, ifm_bit_r;
    logic                    wght_sign_r, mac_done_r;
    logic [LWIDTH-1:0]       len_r;
    logic [MW-1:0]           rand_w_r, wght_abs_r;
    logic [OWIDTH-1:0]       ofm_r;

    logic [LWIDTH-1:0]       len_clamp_s;
    logic [LWIDTH-1:0]       shift_s;
    logic [MW-1:0]           r_i_s, r_w_s, last_s;
    logic                    ibit_s, p_s, last_hit_s;
    logic signed [IWIDTH:0]  acc_next_s;
    logic signed [SW-1:0]    sum_s;

    // Stream sources, product bit, next accumulator and the rescaled sum.
    always_comb begin
        len_clamp_s = (len_log2 > LMAX) ? LMAX : len_log2;
        shift_s     = LMAX - len_r;
        r_i_s       = cnt_r << shift_s;
        r_w_s       = bitrev(cnt_r);
        last_s      = {MW{1'b1}} >> shift_s;
        last_hit_s  = (cnt_r == last_s);
        ibit_s      = (ifm_abs_r > r_i_s);
        p_s         = ibit_s & (wght_abs_r > r_w_s);
        if (!p_s) begin
            acc_next_s = acc_r;
        end else if (ifm_sign_r ^ wght_sign_r) begin
            acc_next_s = acc_r - ACC_ONE;
        end else begin
            acc_next_s = acc_r + ACC_ONE;
        end
        sum_s = SW'($signed(ofm)) + (SW'(acc_r) <<< shift_s);
    end

    // Control FSM with all outputs registered; clr overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {MW{1'b0}};
            acc_r        <= {(IWIDTH+1){1'b0}};
            ifm_abs_r    <= {MW{1'b0}};
            busy_r       <= 1'b0;
            start_d_r    <= 1'b0;
            stream_vld_r <= 1'b0;
            ifm_sign_r   <= 1'b0;
            ifm_bit_r    <= 1'b0;
            wght_sign_r  <= 1'b0;
            mac_done_r   <= 1'b0;
            len_r        <= {LWIDTH{1'b0}};
            rand_w_r     <= {MW{1'b0}};
            wght_abs_r   <= {MW{1'b0}};
            ofm_r        <= {OWIDTH{1'b0}};
        end else if (clr) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {MW{1'b0}};
            acc_r        <= {(IWIDTH+1){1'b0}};
            busy_r       <= 1'b0;
            start_d_r    <= 1'b0;
            stream_vld_r <= 1'b0;
            mac_done_r   <= 1'b0;
        end else begin
            start_d_r  <= 1'b0;
            mac_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        ifm_sign_r  <= ifm[IWIDTH-1];
                        ifm_abs_r   <= sat_abs(ifm);
                        wght_sign_r <= wght_sign;
                        wght_abs_r  <= wght_abs;
                        len_r       <= len_clamp_s;
                        cnt_r       <= {MW{1'b0}};
                        acc_r       <= {(IWIDTH+1){1'b0}};
                        start_d_r   <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    ifm_bit_r    <= ibit_s;
                    rand_w_r     <= r_w_s;
                    stream_vld_r <= 1'b1;
                    acc_r        <= acc_next_s;
                    cnt_r        <= cnt_r + MW'(1);
                    if (last_hit_s) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ofm_r        <= sat_o(sum_s);
                    mac_done_r   <= 1'b1;
                    stream_vld_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    stream_vld_r <= 1'b0;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_r;
    assign start_d      = start_d_r;
    assign len_d        = len_r;
    assign stream_vld_d = stream_vld_r;
    assign ifm_sign_d   = ifm_sign_r;
    assign ifm_bit_d    = ifm_bit_r;
    assign randW_d      = rand_w_r;
    assign wght_sign_d  = wght_sign_r;
    assign wght_abs_d   = wght_abs_r;
    assign ofm_d        = ofm_r;
    assign mac_done_d   = mac_done_r;

endmodule

// File: tb/tb_pe_border_et.sv
// Directed bench for pe_border_et. Expected stream bits, weight random numbers
// and results come from a small behavioural model and are queued when a MAC is
// launched, then popped as the DUT produces them. A second instance with a
// narrower IWIDTH exercises length clamping, since the default len_log2 port
// cannot carry a value above 7.
module tb_pe_border_et;

    logic        clk;
    logic        rst_n, start, clr, wght_sign;
    logic [2:0]  len_log2;
    logic [7:0]  ifm;
    logic [6:0]  wght_abs;
    logic [15:0] ofm;
    logic        busy, start_d, stream_vld_d, ifm_sign_d, ifm_bit_d, wght_sign_d, mac_done_d;
    logic [2:0]  len_d;
    logic [6:0]  randW_d, wght_abs_d;
    logic [15:0] ofm_d;

    logic        start2, ws2;
    logic [2:0]  len2;
    logic [5:0]  ifm2;
    logic [4:0]  wa2;
    logic [15:0] ofm2;
    logic        busy2, start_d2, vld2, isign2, ibit2, wsign2, done2;
    logic [2:0]  len_d2;
    logic [4:0]  rw2, wabs2;
    logic [15:0] ofm_d2;

    int n_checks = 0;
    int n_fail   = 0;
    int qbit[$];
    int qrw[$];
    int qofm[$];

    pe_border_et #(.IWIDTH(8), .OWIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .len_log2(len_log2),
        .ifm(ifm), .wght_sign(wght_sign), .wght_abs(wght_abs), .ofm(ofm),
        .busy(busy), .start_d(start_d), .len_d(len_d), .stream_vld_d(stream_vld_d),
        .ifm_sign_d(ifm_sign_d), .ifm_bit_d(ifm_bit_d), .randW_d(randW_d),
        .wght_sign_d(wght_sign_d), .wght_abs_d(wght_abs_d), .ofm_d(ofm_d),
        .mac_done_d(mac_done_d)
    );

    pe_border_et #(.IWIDTH(6), .OWIDTH(16)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .clr(clr), .len_log2(len2),
        .ifm(ifm2), .wght_sign(ws2), .wght_abs(wa2), .ofm(ofm2),
        .busy(busy2), .start_d(start_d2), .len_d(len_d2), .stream_vld_d(vld2),
        .ifm_sign_d(isign2), .ifm_bit_d(ibit2), .randW_d(rw2),
        .wght_sign_d(wsign2), .wght_abs_d(wabs2), .ofm_d(ofm_d2),
        .mac_done_d(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rev_low(input int c, input int l);
        int r = 0;
        for (int b = 0; b < l; b++) begin
            if (((c >> b) & 1) == 1) r = r | (1 << (l - 1 - b));
        end
        return r;
    endfunction

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Launch one MAC on the IWIDTH=8 instance and score its stream and result.
    task automatic run_mac(input int ifm_v, input bit ws, input int wa, input int len_v,
                           input int ofm_v, input bit hold_start);
        int l, s, ia, acc, nstream, starts, ofm_exp, ri, rw, b, r;
        bit neg, done_seen;
        l   = (len_v > 7) ? 7 : len_v;
        s   = 7 - l;
        ia  = (ifm_v >= 0) ? ifm_v : ((ifm_v == -128) ? 127 : -ifm_v);
        neg = (ifm_v < 0) ^ ws;
        acc = 0;
        for (int c = 0; c < (1 << l); c++) begin
            ri = c << s;
            rw = rev_low(c, l) << s;
            qbit.push_back((ia > ri) ? 1 : 0);
            qrw.push_back(rw);
            if (ia > ri && wa > rw) acc = acc + 1;
        end
        if (neg) acc = -acc;
        qofm.push_back(sat16(ofm_v + acc * (1 << s)));

        @(negedge clk);
        start     = 1'b1;
        len_log2  = 3'(len_v);
        ifm       = 8'(ifm_v);
        wght_sign = ws;
        wght_abs  = 7'(wa);
        ofm       = 16'(ofm_v);
        @(negedge clk);
        check("start_d_accept", start_d, 1);
        check("busy_run", busy, 1);
        check("len_d", len_d, l);
        if (!hold_start) start = 1'b0;

        done_seen = 1'b0;
        nstream   = 0;
        starts    = 0;
        for (int cyc = 1; cyc <= (1 << l) + 4 && !done_seen; cyc++) begin
            @(negedge clk);
            if (start_d) starts++;
            if (stream_vld_d && qbit.size() > 0) begin
                b = qbit.pop_front();
                r = qrw.pop_front();
                check("ifm_bit_d", ifm_bit_d, b);
                check("randW_d", randW_d, r);
                nstream++;
            end
            if (mac_done_d) begin
                done_seen = 1'b1;
                start     = 1'b0;
                check("done_edge", cyc, (1 << l) + 1);
                check("stream_vld_in_done", stream_vld_d, 0);
                if (qofm.size() > 0) begin
                    ofm_exp = qofm.pop_front();
                    check("ofm_d", $signed(ofm_d), ofm_exp);
                end
            end
        end
        start = 1'b0;
        check("done_seen", done_seen, 1);
        check("stream_len", nstream, 1 << l);
        check("start_d_ignored", starts, 0);
        qbit.delete();
        qrw.delete();
        qofm.delete();
        @(negedge clk);
        check("done_one_cycle", mac_done_d, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ofm_prev, dones, cyc2, acc2;
        bit seen2;
        rst_n = 1'b0; start = 1'b0; clr = 1'b0; len_log2 = 3'd0; ifm = 8'd0;
        wght_sign = 1'b0; wght_abs = 7'd0; ofm = 16'd0;
        start2 = 1'b0; ws2 = 1'b0; len2 = 3'd0; ifm2 = 6'd0; wa2 = 5'd0; ofm2 = 16'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ofm_d", ofm_d, 0);
        check("rst_done", mac_done_d, 0);
        check("rst_vld", stream_vld_d, 0);
        rst_n = 1'b1;

        // Full-length MAC and the most-negative activation.
        run_mac(127, 1'b0, 64, 7, 0, 1'b0);
        run_mac(-128, 1'b0, 64, 7, 10, 1'b0);
        check("ifm_sign_d_neg", ifm_sign_d, 1);
        // Early termination with L=1.
        run_mac(100, 1'b0, 100, 1, 0, 1'b0);
        // Output saturation in both directions.
        run_mac(127, 1'b0, 127, 7, 32767, 1'b0);
        run_mac(127, 1'b1, 127, 7, -32768, 1'b0);
        // start held high throughout a MAC, zero operand, mixed signs.
        run_mac(50, 1'b1, 30, 7, 1000, 1'b1);
        run_mac(0, 1'b0, 100, 3, -5, 1'b0);
        run_mac(-77, 1'b1, 90, 4, 300, 1'b0);

        // Abort at count 40 of an L=7 run.
        ofm_prev = int'(ofm_d);
        @(negedge clk);
        start = 1'b1; len_log2 = 3'd7; ifm = 8'd127; wght_sign = 1'b0;
        wght_abs = 7'd127; ofm = 16'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_vld", stream_vld_d, 0);
        check("abort_done", mac_done_d, 0);
        check("abort_ofm_hold", ofm_d, ofm_prev);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mac_done_d) dones++;
        end
        check("abort_no_done", dones, 0);
        run_mac(100, 1'b0, 100, 1, 0, 1'b0);

        // start and clr together stay in IDLE.
        @(negedge clk);
        start = 1'b1; clr = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        check("start_clr_busy", busy, 0);
        check("start_clr_start_d", start_d, 0);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        start = 1'b1; len_log2 = 3'd7; ifm = 8'd90; wght_sign = 1'b1;
        wght_abs = 7'd80; ofm = 16'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_vld", stream_vld_d, 0);
        check("mid_rst_randW", randW_d, 0);
        check("mid_rst_wabs", wght_abs_d, 0);
        check("mid_rst_wsign", wght_sign_d, 0);
        check("mid_rst_ofm", ofm_d, 0);
        check("mid_rst_len", len_d, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_mac(-20, 1'b0, 127, 5, -100, 1'b0);

        // Length clamp on the IWIDTH=6 instance: len_log2=7 becomes L=5.
        acc2 = 0;
        for (int c = 0; c < 32; c++) begin
            if (31 > c && 31 > rev_low(c, 5)) acc2++;
        end
        @(negedge clk);
        start2 = 1'b1; len2 = 3'd7; ifm2 = 6'd31; ws2 = 1'b0; wa2 = 5'd31; ofm2 = 16'd0;
        @(negedge clk);
        start2 = 1'b0;
        check("clamp_len_d", len_d2, 5);
        seen2 = 1'b0;
        cyc2  = 0;
        for (int cyc = 1; cyc <= 40 && !seen2; cyc++) begin
            @(negedge clk);
            if (done2) begin
                seen2 = 1'b1;
                cyc2  = cyc;
                check("clamp_ofm_d", $signed(ofm_d2), acc2);
            end
        end
        check("clamp_done_edge", cyc2, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
